inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Producer side of the decoder's 32-bit `inst` input. Fetches instructions from the byte-wide memory
//  port, assembles them little-endian and presents them with their PC through a valid/ready handshake.
//  Sits between the memory arbiter and decode/issue; accepts PC redirects from branch/jump resolution.
// PARAMETERS
//  ICACHE_LINES  64  direct-mapped I-cache entries, one 32-bit instruction each (power of 2; ICACHE_EN only)
//  RESET_PC      0   PC loaded on reset
// PORTS
//  clk_in        in   1   clock
//  rst_in        in   1   synchronous reset, active-high
//  rdy_in        in   1   global enable; low freezes all state
//  jump_en       in   1   redirect request; highest priority
//  jump_pc       in   32  redirect target
//  mem_grant     in   1   arbiter grants the read port this cycle
//  mem_rd_en     out  1   byte read request
//  mem_addr      out  32  byte address of the request
//  mem_din       in   8   read data; valid the cycle after a granted request
//  inst_valid    out  1   inst/inst_pc hold a fetched instruction
//  inst_ready    in   1   consumer accepts this cycle
//  inst          out  32  instruction word, fed to decode
//  inst_pc       out  32  address of inst
// BEHAVIOUR
//  Reset (rst_in=1 at posedge): pc=RESET_PC, state=IDLE, inst_valid=0, mem_rd_en=0, mem_addr=0, inst=0,
//   inst_pc=0, byte counters=0; with ICACHE_EN all valid bits cleared. Reset mid-fetch abandons it; a
//   byte returning the cycle after reset is discarded.
//  FSM IDLE -> FETCH -> OUT -> IDLE (registered state):
//   IDLE : ICACHE_EN hit -> load inst/inst_pc, inst_valid=1, go OUT (1-cycle latency); else FETCH, iss=0, rcv=0.
//   FETCH: mem_rd_en=1 while iss<4, mem_addr=pc+iss; iss increments only on mem_grant.
//          Byte from a granted request lands next cycle in inst[8*rcv+:8], rcv++. rcv==4 -> OUT, inst_valid=1.
//          Grant stall holds mem_addr and iss stable. Full-grant latency: issue t..t+3, data t+1..t+4,
//          inst_valid high at t+5.
//   OUT  : hold inst/inst_pc/inst_valid stable until inst_valid&&inst_ready; on transfer pc+=4,
//          inst_valid=0, go IDLE. Back-to-back: next fetch starts the cycle after transfer.
//  Redirect: jump_en=1 at posedge (any state) -> pc=jump_pc, inst_valid=0, mem_rd_en=0, state=IDLE,
//   counters cleared; an in-flight byte from the previous cycle is dropped (stale flag). Same-cycle
//   jump_en and inst transfer: jump wins, pc=jump_pc (not +4); consumer flushes on jump_en too.
//  rdy_in=0: no state/output change, no new request (mem_rd_en=0); a byte for a request granted in
//   the preceding cycle is still captured. jump_en/inst_ready ignored while rdy_in=0.
//  pc arithmetic mod 2^32; 0xFFFFFFFC+4 wraps to 0. Byte addresses pc+0..3 wrap likewise. No alignment check.
// CONFIGURATION
//  ICACHE_EN defined: icache_dm instantiated; index=pc[log2(ICACHE_LINES)+1:2], tag=remaining upper bits.
//   FETCH completion writes the line (unless killed by jump/reset). Hit in IDLE skips memory entirely.
//   No invalidation except reset (instruction memory is read-only at run time).
//  ICACHE_EN undefined: no cache storage; every instruction takes the FETCH path.
// STRUCTURE
//  info.v: fetch FSM state encodings (IF_IDLE/IF_FETCH/IF_OUT), ICACHE index/tag width macros, `DATA_WIDTH.
//  Sub-module icache_dm (lookup comb: hit/data; write port: en/index/tag/data; sync reset of valids);
//   compiled only under ICACHE_EN.
// TESTING
//  1 Reset, mem bytes @0..3 = 13 05 A0 00, grant always 1, ready 1 -> inst=0x00A00513, inst_pc=0, valid at cycle 5.
//  2 Grant toggling 1,0,1,0... -> mem_addr held during low cycles; same inst assembled; no duplicate/missed bytes.
//  3 inst_ready=0 for 10 cycles in OUT -> inst/inst_pc stable, mem_rd_en=0; after accept next fetch at pc=4.
//  4 jump_en with jump_pc=0x1000 while rcv=2 -> stale byte dropped; next inst_pc=0x1000 with bytes from 0x1000..3.
//  5 jump_en and inst transfer same cycle -> pc=jump_pc, not pc+4; rdy_in low mid-FETCH -> resumes, same word.
//  6 ICACHE_EN: loop jump back to 0x0 after first pass -> second fetch of 0x0 valid 1 cycle after IDLE, mem_rd_en stays 0.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: fetch FSM encodings, word width,
// I-cache geometry helpers and the little-endian byte insertion helper.
package inst_fetcher_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] IF_IDLE  = 2'd0;
  localparam logic [1:0] IF_FETCH = 2'd1;
  localparam logic [1:0] IF_OUT   = 2'd2;

  function automatic int icache_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int icache_tag_w(input int lines);
    return 30 - $clog2(lines);
  endfunction

  // Byte lane idx of the assembled word receives b; lane 0 is the lowest address.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[8*idx +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line; combinational lookup,
// single write port, valid bits cleared only by reset. Used only when ICACHE_EN is defined.
module icache_dm
  import inst_fetcher_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = icache_idx_w(64),
  parameter int TAG_W = icache_tag_w(64)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  assign hit      = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
  assign hit_data = data_r[rd_index];

  // Valid bits: cleared by reset, set when a completed fetch fills the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data storage needs no reset; a line is never read while its valid bit is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: reads four bytes per instruction over the byte memory port and hands
// the little-endian word plus its PC to decode. Optional I-cache under macro ICACHE_EN.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef ICACHE_EN
  , parameter int ICACHE_LINES = 64
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  jump_en,
  input  logic [31:0]           jump_pc,
  input  logic                  mem_grant,
  output logic                  mem_rd_en,
  output logic [31:0]           mem_addr,
  input  logic [7:0]            mem_din,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc
);

  logic [1:0]            state_r;
  logic [31:0]           pc_r;
  logic [2:0]            iss_r;
  logic [2:0]            rcv_r;
  logic                  req_r;
  logic                  pend_r;
  logic [31:0]           addr_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic [31:0]           inst_pc_r;
  logic                  valid_r;

  logic                  granted_s;
  logic [2:0]            iss_inc_s;
  logic [31:0]           word_s;
  logic                  done_s;
  logic [31:0]           done_word_s;
  logic                  hit_s;
  logic [31:0]           hit_data_s;

  // A request is never presented while the block is frozen.
  assign mem_rd_en  = req_r & rdy_in;
  assign mem_addr   = addr_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = valid_r;

  assign granted_s   = mem_rd_en & mem_grant;
  assign iss_inc_s   = iss_r + 3'd1;
  assign word_s      = put_byte(inst_r, rcv_r[1:0], mem_din);
  // Completion: either the fourth byte lands now, or it landed while frozen.
  assign done_s      = (state_r == IF_FETCH) && ((pend_r && (rcv_r == 3'd3)) || (rcv_r == 3'd4));
  assign done_word_s = pend_r ? word_s : inst_r;

`ifdef ICACHE_EN
  localparam int IDX_W = icache_idx_w(ICACHE_LINES);
  localparam int TAG_W = icache_tag_w(ICACHE_LINES);

  logic wr_en_s;
  assign wr_en_s = rdy_in && !jump_en && !rst_in && done_s;

  icache_dm #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk      (clk_in),
    .rst      (rst_in),
    .rd_index (pc_r[IDX_W+1:2]),
    .rd_tag   (pc_r[31:IDX_W+2]),
    .hit      (hit_s),
    .hit_data (hit_data_s),
    .wr_en    (wr_en_s),
    .wr_index (pc_r[IDX_W+1:2]),
    .wr_tag   (pc_r[31:IDX_W+2]),
    .wr_data  (done_word_s)
  );
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'h0000_0000;
`endif

  // Fetch FSM; priority is reset, freeze, redirect, then normal state behaviour.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= IF_IDLE;
      pc_r      <= RESET_PC;
      iss_r     <= 3'd0;
      rcv_r     <= 3'd0;
      req_r     <= 1'b0;
      pend_r    <= 1'b0;
      addr_r    <= 32'h0000_0000;
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
    end else if (!rdy_in) begin
      // Frozen, but a byte already granted last cycle must not be lost.
      pend_r <= 1'b0;
      if (pend_r) begin
        inst_r <= word_s;
        rcv_r  <= rcv_r + 3'd1;
      end
    end else if (jump_en) begin
      state_r <= IF_IDLE;
      pc_r    <= jump_pc;
      iss_r   <= 3'd0;
      rcv_r   <= 3'd0;
      req_r   <= 1'b0;
      pend_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IF_IDLE: begin
          if (hit_s) begin
            inst_r    <= hit_data_s;
            inst_pc_r <= pc_r;
            valid_r   <= 1'b1;
            state_r   <= IF_OUT;
          end else begin
            state_r <= IF_FETCH;
            iss_r   <= 3'd0;
            rcv_r   <= 3'd0;
            req_r   <= 1'b1;
            addr_r  <= pc_r;
          end
        end
        IF_FETCH: begin
          pend_r <= granted_s;
          if (granted_s) begin
            iss_r  <= iss_inc_s;
            addr_r <= pc_r + {29'd0, iss_inc_s};
            req_r  <= (iss_inc_s != 3'd4);
          end
          if (pend_r) begin
            inst_r <= word_s;
            rcv_r  <= rcv_r + 3'd1;
          end
          if (done_s) begin
            state_r   <= IF_OUT;
            valid_r   <= 1'b1;
            inst_pc_r <= pc_r;
            req_r     <= 1'b0;
          end
        end
        IF_OUT: begin
          if (inst_ready) begin
            pc_r    <= pc_r + 32'd4;
            valid_r <= 1'b0;
            state_r <= IF_IDLE;
          end
        end
        default: begin
          state_r <= IF_IDLE;
          req_r   <= 1'b0;
          pend_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: byte memory responder, transaction-level reference
// model checked every cycle, and directed scenarios with hand-computed literal expectations.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        mem_grant = 1'b1;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din = 8'hEE;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int gmode    = 0;

  always #5 clk_in = ~clk_in;

  inst_fetcher dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc),
    .mem_grant  (mem_grant),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  // Memory image: fixed program bytes at 0..3, a simple address hash elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd7) + a[15:8] + 8'h31;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Memory side: grant pattern and read data one cycle after a granted request.
  always @(posedge clk_in) begin
    if (gmode == 1) mem_grant <= ~mem_grant;
    else mem_grant <= 1'b1;
    if (mem_rd_en && mem_grant) mem_din <= mb(mem_addr);
    else mem_din <= 8'hEE;
  end

  // Reference model: expected PC stream, request addresses, hold behaviour.
  initial begin : compare
    logic        armed;
    logic [31:0] exp_pc;
    int          k;
    logic        p_stall, p_hold;
    logic [31:0] p_addr, p_inst, p_pc;
    armed = 1'b0; exp_pc = 32'h0; k = 0;
    p_stall = 1'b0; p_hold = 1'b0; p_addr = 32'h0; p_inst = 32'h0; p_pc = 32'h0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        armed = 1'b1; exp_pc = 32'h0; k = 0; p_stall = 1'b0; p_hold = 1'b0;
      end else if (armed) begin
        if (!rdy_in || inst_valid) check1("no_req", mem_rd_en, 1'b0);
        if (p_stall && mem_rd_en) check("stall_addr", mem_addr, p_addr);
        if (p_hold) begin
          check1("hold_valid", inst_valid, 1'b1);
          check("hold_inst", inst, p_inst);
          check("hold_pc", inst_pc, p_pc);
        end
        if (mem_rd_en && mem_grant) begin
          check1("req_count", k < 4, 1'b1);
          check("req_addr", mem_addr, exp_pc + 32'(k));
          k++;
        end
        if (rdy_in && jump_en) begin
          exp_pc = jump_pc; k = 0;
        end else if (rdy_in && inst_valid && inst_ready) begin
          check("xfer_pc", inst_pc, exp_pc);
          check("xfer_inst", inst, exp_word(exp_pc));
          exp_pc = exp_pc + 32'd4; k = 0;
        end
        p_stall = mem_rd_en && !mem_grant && rdy_in && !jump_en;
        p_hold  = inst_valid && !(rdy_in && (inst_ready || jump_en));
        p_addr  = mem_addr; p_inst = inst; p_pc = inst_pc;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (mem_rd_en) break;
    end
    check1("wait_req", mem_rd_en, 1'b1);
  endtask

  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (inst_valid) break;
    end
    check1("wait_valid", inst_valid, 1'b1);
  endtask

  task automatic wait_xfer(input int lim);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (inst_valid && inst_ready && rdy_in && !jump_en) begin
        seen = 1'b1;
        break;
      end
    end
    check1("wait_xfer", seen, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    rst_in = 1'b1; rdy_in = 1'b1; jump_en = 1'b0; jump_pc = 32'h0; inst_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk_in);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    tick();
    rst_in = 1'b0;

    // Full-grant fetch: first request at t, valid at t+5.
    wait_req(20);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      cnt++;
      if (inst_valid) break;
    end
    check("latency", cnt, 5);
    check("first_inst", inst, 32'h00A00513);
    check("first_pc", inst_pc, 32'h0);

    // Toggling grant.
    tick();
    gmode = 1;
    wait_xfer(100);
    wait_xfer(100);
    tick();
    gmode = 0;

    // Consumer stall for 10 cycles.
    inst_ready = 1'b0;
    wait_valid(40);
    check("stall_pc", inst_pc, 32'h0000000C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      check1("stall_valid", inst_valid, 1'b1);
      check1("stall_rd_en", mem_rd_en, 1'b0);
    end
    tick();
    inst_ready = 1'b1;
    wait_xfer(20);
    tick();
    inst_ready = 1'b0;
    wait_req(20);
    check("next_fetch_addr", mem_addr, 32'h00000010);

    // Redirect with two bytes received and one in flight.
    repeat (3) tick();
    jump_en = 1'b1; jump_pc = 32'h00001000;
    tick();
    jump_en = 1'b0;
    wait_valid(40);
    check("jump_pc", inst_pc, 32'h00001000);
    check("jump_inst", inst, 32'h564F4841);

    // Redirect coinciding with a transfer, then a freeze mid-fetch.
    tick();
    inst_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h00002000;
    tick();
    jump_en = 1'b0; inst_ready = 1'b0;
    wait_req(20);
    tick();
    tick();
    rdy_in = 1'b0;
    repeat (4) tick();
    rdy_in = 1'b1;
    wait_valid(40);
    check("jx_pc", inst_pc, 32'h00002000);
    check("jx_inst", inst, 32'h665F5851);

    // PC wrap at the top of the address space.
    tick();
    jump_en = 1'b1; jump_pc = 32'hFFFFFFFC;
    tick();
    jump_en = 1'b0;
    wait_valid(40);
    check("wrap_top_pc", inst_pc, 32'hFFFFFFFC);
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_valid(40);
    check("wrap_pc", inst_pc, 32'h0);
    check("wrap_inst", inst, 32'h00A00513);

    // Loop back to 0 after it has been fetched once.
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_valid(40);
    check("loop_pre_pc", inst_pc, 32'h00000004);
    tick();
    jump_en = 1'b1; jump_pc = 32'h0;
    tick();
    jump_en = 1'b0;
    @(negedge clk_in);
    check1("loop_idle_valid", inst_valid, 1'b0);
    check1("loop_idle_rd_en", mem_rd_en, 1'b0);
`ifdef ICACHE_EN
    @(negedge clk_in);
    check1("cache_hit_valid", inst_valid, 1'b1);
    check1("cache_hit_rd_en", mem_rd_en, 1'b0);
`else
    wait_valid(40);
`endif
    check("loop_inst", inst, 32'h00A00513);
    check("loop_pc", inst_pc, 32'h0);

    // Free-running stream with the consumer always ready.
    tick();
    inst_ready = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
